// File: rtl/i2s_tx_if.sv
// Sample stream into the I2S transmitter: one stereo PCM pair per valid/ready handshake.
//   s_left, s_right : two's-complement samples, DATA_SIZE bits each
//   s_valid         : pair present (driven by the source)
//   s_ready         : transmitter holding register is free (driven by the sink)
interface i2s_tx_if #(
   parameter int unsigned DATA_SIZE = 24
) ();
   logic [DATA_SIZE-1:0] s_left;
   logic [DATA_SIZE-1:0] s_right;
   logic                 s_valid;
   logic                 s_ready;

   modport master (
      output s_left,
      output s_right,
      output s_valid,
      input  s_ready
   );

   modport slave (
      input  s_left,
      input  s_right,
      input  s_valid,
      output s_ready
   );
endinterface

// File: rtl/i2s_tx.sv
// Philips-format I2S master transmitter.
// Generates SCK/WS from clk and shifts out stereo frames of 2*SLOT_WIDTH bits, MSB first,
// samples left-aligned in each slot. A one-entry holding register decouples the stream from
// frame timing; a frame loaded with the holding register empty sends zeros and sets underrun.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   en_i              : transmitter enable; low discards the current frame
//   s_if              : sample stream (slave side)
//   i2s_clk_o         : bit clock (SCK)
//   i2s_ws_o          : word select, 0 = left, 1 = right
//   i2s_sd_o          : serial data
//   frame_start_o     : one-cycle pulse on each frame load
//   underrun_o        : sticky underrun flag
//   clr_underrun_i    : clears underrun (a simultaneous set wins)
module i2s_tx #(
   parameter int unsigned CLK_FREQ     = 50_000_000,
   parameter int unsigned I2S_CLK_FREQ = 1_500_000,
   parameter int unsigned DATA_SIZE    = 24,
   parameter int unsigned SLOT_WIDTH   = 32
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    en_i,
   i2s_tx_if.slave s_if,
   output logic    i2s_clk_o,
   output logic    i2s_ws_o,
   output logic    i2s_sd_o,
   output logic    frame_start_o,
   output logic    underrun_o,
   input  logic    clr_underrun_i
);

   localparam int unsigned HalfDivRaw = CLK_FREQ / (2 * I2S_CLK_FREQ);
   localparam int unsigned HALF_DIV   = (HalfDivRaw < 1) ? 1 : HalfDivRaw;
   localparam int unsigned FrameBits  = 2 * SLOT_WIDTH;
   localparam int unsigned PadW       = SLOT_WIDTH - DATA_SIZE;
   localparam int unsigned CntW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int unsigned NW         = $clog2(FrameBits);

   localparam logic [CntW-1:0] CntMax  = CntW'(HALF_DIV - 1);
   localparam logic [NW-1:0]   NLast   = NW'(FrameBits - 1);
   localparam logic [NW-1:0]   WsFirst = NW'(SLOT_WIDTH - 1);
   localparam logic [NW-1:0]   WsLast  = NW'(FrameBits - 2);

   logic [CntW-1:0]      count_q, count_d;
   logic                 sck_q, sck_d;
   logic [NW-1:0]        n_q, n_d;
   logic                 ws_q, ws_d;
   logic                 sd_q, sd_d;
   logic [FrameBits-1:0] shift_q, shift_d;
   logic [DATA_SIZE-1:0] hold_l_q, hold_l_d;
   logic [DATA_SIZE-1:0] hold_r_q, hold_r_d;
   logic                 hold_valid_q, hold_valid_d;
   logic                 underrun_q, underrun_d;
   logic                 frame_start_q, frame_start_d;

   logic                  handshake;
   logic                  fall;
   logic                  load;
   logic [SLOT_WIDTH-1:0] slot_l;
   logic [SLOT_WIDTH-1:0] slot_r;

   assign handshake = s_if.s_valid & ~hold_valid_q;
   // Left-align each sample in its slot, zero padding below the LSB.
   assign slot_l    = SLOT_WIDTH'(hold_l_q) << PadW;
   assign slot_r    = SLOT_WIDTH'(hold_r_q) << PadW;

   always_comb begin
      count_d       = count_q;
      sck_d         = sck_q;
      n_d           = n_q;
      ws_d          = ws_q;
      sd_d          = sd_q;
      shift_d       = shift_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      hold_valid_d  = hold_valid_q;
      underrun_d    = underrun_q;
      frame_start_d = 1'b0;
      fall          = 1'b0;
      load          = 1'b0;

      if (!en_i) begin
         // Disable drops the frame in flight; the next enable restarts at a frame boundary.
         count_d = '0;
         sck_d   = 1'b0;
         n_d     = NLast;
         ws_d    = 1'b0;
         sd_d    = 1'b0;
         shift_d = '0;
      end else begin
         if (count_q == CntMax) begin
            count_d = '0;
            sck_d   = ~sck_q;
            fall    = sck_q;
         end else begin
            count_d = count_q + 1'b1;
         end

         if (fall) begin
            n_d = (n_q == NLast) ? '0 : n_q + 1'b1;
            if (n_d == '0) begin
               load    = 1'b1;
               shift_d = hold_valid_q ? {slot_l, slot_r} : '0;
            end
            // WS/SD change with the SCK falling edge so the receiver sees them settled
            // at the next rising edge; WS leads each slot MSB by one bit.
            sd_d = shift_d[NLast - n_d];
            ws_d = (n_d >= WsFirst) && (n_d <= WsLast);
         end
      end

      frame_start_d = load;

      // Empty hold at a load with a same-cycle handshake: zeros go out, pair waits a frame.
      if (handshake) begin
         hold_valid_d = 1'b1;
         hold_l_d     = s_if.s_left;
         hold_r_d     = s_if.s_right;
      end else if (load) begin
         hold_valid_d = 1'b0;
      end

      if (load && !hold_valid_q) begin
         underrun_d = 1'b1;
      end else if (clr_underrun_i) begin
         underrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q       <= '0;
         sck_q         <= 1'b0;
         n_q           <= NLast;
         ws_q          <= 1'b0;
         sd_q          <= 1'b0;
         shift_q       <= '0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         hold_valid_q  <= 1'b0;
         underrun_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         count_q       <= count_d;
         sck_q         <= sck_d;
         n_q           <= n_d;
         ws_q          <= ws_d;
         sd_q          <= sd_d;
         shift_q       <= shift_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         hold_valid_q  <= hold_valid_d;
         underrun_q    <= underrun_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign s_if.s_ready  = ~hold_valid_q;
   assign i2s_clk_o     = sck_q;
   assign i2s_ws_o      = ws_q;
   assign i2s_sd_o      = sd_q;
   assign frame_start_o = frame_start_q;
   assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a default-parameter instance (HALF_DIV 16, 24-in-32 slots) and a small
// instance (HALF_DIV 4, 16-in-16 slots). A receiver model samples SD/WS on rising SCK after
// each frame_start and compares the frame against a scoreboard of expected frames.
module tb_i2s_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_a, en_a, clr_a, a_sck, a_ws, a_sd, a_fs, a_ur;
   logic rst_b, en_b, clr_b, b_sck, b_ws, b_sd, b_fs, b_ur;

   i2s_tx_if #(.DATA_SIZE(24)) if_a ();
   i2s_tx_if #(.DATA_SIZE(16)) if_b ();

   i2s_tx dut_a (
      .clk           (clk),
      .rst           (rst_a),
      .en_i          (en_a),
      .s_if          (if_a),
      .i2s_clk_o     (a_sck),
      .i2s_ws_o      (a_ws),
      .i2s_sd_o      (a_sd),
      .frame_start_o (a_fs),
      .underrun_o    (a_ur),
      .clr_underrun_i(clr_a)
   );

   i2s_tx #(
      .CLK_FREQ    (8),
      .I2S_CLK_FREQ(1),
      .DATA_SIZE   (16),
      .SLOT_WIDTH  (16)
   ) dut_b (
      .clk           (clk),
      .rst           (rst_b),
      .en_i          (en_b),
      .s_if          (if_b),
      .i2s_clk_o     (b_sck),
      .i2s_ws_o      (b_ws),
      .i2s_sd_o      (b_sd),
      .frame_start_o (b_fs),
      .underrun_o    (b_ur),
      .clr_underrun_i(clr_b)
   );

   localparam logic [63:0] WS_A = 64'h0000_0001_FFFF_FFFE;  // high for n = 31..62
   localparam logic [63:0] WS_B = 64'h0000_0000_0001_FFFE;  // high for n = 15..30

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic [63:0] sd;
   } vec_t;

   vec_t vecs [5];

   int checks = 0;
   int errors = 0;
   logic [63:0] sb_a [$];
   logic [63:0] sb_b [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic get_sck(input bit w);
      return w ? b_sck : a_sck;
   endfunction
   function automatic logic get_sd(input bit w);
      return w ? b_sd : a_sd;
   endfunction
   function automatic logic get_ws(input bit w);
      return w ? b_ws : a_ws;
   endfunction
   function automatic logic get_fs(input bit w);
      return w ? b_fs : a_fs;
   endfunction
   function automatic logic get_ready(input bit w);
      return w ? if_b.s_ready : if_a.s_ready;
   endfunction

   // Waits for a frame_start pulse; reports the cycle it was seen.
   task automatic wait_fs(input bit w, input int limit, output int unsigned at);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!get_fs(w) && t < limit);
      at = cyc;
      check(w ? "b_frame_start_seen" : "a_frame_start_seen", 64'(get_fs(w)), 64'd1);
   endtask

   // Receiver model: samples SD/WS on each rising SCK, first bit ends up in the MSB.
   task automatic collect(input bit w, output logic [63:0] sdb, output logic [63:0] wsb,
                          output int span);
      int   bits  = w ? 32 : 64;
      int   got   = 0;
      int   t     = 0;
      int   first = 0;
      logic prev;
      logic cur;
      sdb  = '0;
      wsb  = '0;
      span = 0;
      prev = get_sck(w);
      while (got < bits && t < 5000) begin
         @(negedge clk);
         t++;
         cur = get_sck(w);
         if (cur && !prev) begin
            if (got == 0) first = t;
            sdb  = {sdb[62:0], get_sd(w)};
            wsb  = {wsb[62:0], get_ws(w)};
            got++;
            span = t - first;
         end
         prev = cur;
      end
      check(w ? "b_collect_bits" : "a_collect_bits", 64'(got), 64'(bits));
   endtask

   task automatic check_frame(input bit w, input string tag);
      logic [63:0] sdb;
      logic [63:0] wsb;
      logic [63:0] exp_sd;
      int          span;
      bit          have;
      collect(w, sdb, wsb, span);
      have = w ? (sb_b.size() != 0) : (sb_a.size() != 0);
      check({tag, "_expected_queued"}, 64'(have), 64'd1);
      exp_sd = '0;
      if (have) begin
         if (w) exp_sd = sb_b.pop_front();
         else   exp_sd = sb_a.pop_front();
      end
      check({tag, "_sd"}, sdb, exp_sd);
      check({tag, "_ws"}, wsb, w ? WS_B : WS_A);
      check({tag, "_bit_span"}, 64'(span), w ? 64'd248 : 64'd2016);
   endtask

   // Called at a negedge: waits for s_ready, does one handshake, queues the expected frame.
   task automatic push_pair(input bit w, input logic [23:0] l, input logic [23:0] r,
                            input logic [63:0] exp_sd);
      int t = 0;
      while (!get_ready(w) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check(w ? "b_ready_before_push" : "a_ready_before_push", 64'(get_ready(w)), 64'd1);
      if (w) begin
         if_b.s_left  = l[15:0];
         if_b.s_right = r[15:0];
         if_b.s_valid = 1'b1;
         sb_b.push_back(exp_sd);
      end else begin
         if_a.s_left  = l;
         if_a.s_right = r;
         if_a.s_valid = 1'b1;
         sb_a.push_back(exp_sd);
      end
      @(posedge clk);
      #1;
      if_a.s_valid = 1'b0;
      if_b.s_valid = 1'b0;
      @(negedge clk);
      check(w ? "b_ready_low_after_push" : "a_ready_low_after_push", 64'(get_ready(w)), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned t_en;
      int unsigned t_fs;
      int unsigned t_prev;

      vecs[0] = '{l: 24'h800001, r: 24'h7FFFFE, sd: 64'h80000100_7FFFFE00};
      vecs[1] = '{l: 24'h123456, r: 24'hABCDEF, sd: 64'h12345600_ABCDEF00};
      vecs[2] = '{l: 24'hFFFFFF, r: 24'h000000, sd: 64'hFFFFFF00_00000000};
      vecs[3] = '{l: 24'h000001, r: 24'h800000, sd: 64'h00000100_80000000};
      vecs[4] = '{l: 24'h5A5A5A, r: 24'hA5A5A5, sd: 64'h5A5A5A00_A5A5A500};

      t_en   = 0;
      t_fs   = 0;
      t_prev = 0;
      rst_a  = 1'b1;
      rst_b  = 1'b1;
      en_a   = 1'b0;
      en_b   = 1'b0;
      clr_a  = 1'b0;
      clr_b  = 1'b0;
      if_a.s_valid = 1'b0;
      if_a.s_left  = '0;
      if_a.s_right = '0;
      if_b.s_valid = 1'b0;
      if_b.s_left  = '0;
      if_b.s_right = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);

      check("a_reset_outputs", 64'({a_sck, a_ws, a_sd, a_fs, a_ur}), 64'd0);
      check("a_reset_ready", 64'(if_a.s_ready), 64'd1);
      check("b_reset_outputs", 64'({b_sck, b_ws, b_sd, b_fs, b_ur}), 64'd0);
      check("b_reset_ready", 64'(if_b.s_ready), 64'd1);

      // Default instance: first pair before the first fall, then a back-to-back stream.
      fork
         begin
            en_a = 1'b1;
            t_en = cyc;
            for (int i = 0; i < 5; i++) push_pair(1'b0, vecs[i].l, vecs[i].r, vecs[i].sd);
         end
         begin
            for (int i = 0; i < 5; i++) begin
               wait_fs(1'b0, 2100, t_fs);
               if (i == 0) check("a_first_fall_latency", 64'(t_fs - t_en), 64'd32);
               else        check("a_frame_period", 64'(t_fs - t_prev), 64'd2048);
               t_prev = t_fs;
               check("a_no_underrun", 64'(a_ur), 64'd0);
               check_frame(1'b0, "a_stream");
            end
         end
      join

      // Stream stops: next frame is empty and raises underrun.
      sb_a.push_back(64'd0);
      wait_fs(1'b0, 2100, t_fs);
      check("a_empty_period", 64'(t_fs - t_prev), 64'd2048);
      check("a_underrun_set", 64'(a_ur), 64'd1);
      t_prev = t_fs;
      fork
         begin
            repeat (100) @(negedge clk);
            clr_a = 1'b1;
            @(negedge clk);
            clr_a = 1'b0;
            check("a_underrun_cleared", 64'(a_ur), 64'd0);
            // Land a handshake (and a clear) on the next load edge with the hold empty.
            repeat (1946) @(negedge clk);
            check("a_ready_at_load_edge", 64'(if_a.s_ready), 64'd1);
            if_a.s_left  = 24'h13579B;
            if_a.s_right = 24'hECA864;
            if_a.s_valid = 1'b1;
            clr_a        = 1'b1;
            sb_a.push_back(64'd0);
            sb_a.push_back(64'h13579B00_ECA86400);
            @(posedge clk);
            #1;
            if_a.s_valid = 1'b0;
            clr_a        = 1'b0;
         end
         check_frame(1'b0, "a_empty1");
      join

      wait_fs(1'b0, 100, t_fs);
      check("a_load_edge_period", 64'(t_fs - t_prev), 64'd2048);
      check("a_underrun_set_wins", 64'(a_ur), 64'd1);
      check("a_late_pair_held", 64'(if_a.s_ready), 64'd0);
      t_prev = t_fs;
      check_frame(1'b0, "a_empty2");

      wait_fs(1'b0, 100, t_fs);
      check("a_late_pair_period", 64'(t_fs - t_prev), 64'd2048);
      check("a_underrun_sticky", 64'(a_ur), 64'd1);
      check("a_hold_freed", 64'(if_a.s_ready), 64'd1);
      check_frame(1'b0, "a_late_pair");

      // Disable mid-frame at n = 40 with a pair held, then re-enable.
      wait_fs(1'b0, 100, t_fs);
      push_pair(1'b0, 24'h2468AC, 24'hFDB975, 64'h2468AC00_FDB97500);
      while (cyc < t_fs + 1290) @(negedge clk);
      check("a_ws_at_n40", 64'(a_ws), 64'd1);
      en_a = 1'b0;
      @(negedge clk);
      check("a_disable_outputs", 64'({a_sck, a_ws, a_sd}), 64'd0);
      check("a_disable_hold_kept", 64'(if_a.s_ready), 64'd0);
      check("a_disable_underrun_kept", 64'(a_ur), 64'd1);
      repeat (50) @(negedge clk);
      check("a_disabled_idle", 64'({a_sck, a_fs}), 64'd0);
      en_a = 1'b1;
      t_en = cyc;
      wait_fs(1'b0, 100, t_fs);
      check("a_reenable_latency", 64'(t_fs - t_en), 64'd32);
      check_frame(1'b0, "a_reenable");
      en_a = 1'b0;
      check("a_scoreboard_drained", 64'(sb_a.size()), 64'd0);

      // Small instance: 8-clk bit period, full-width samples, then reset mid-frame.
      fork
         begin
            en_b = 1'b1;
            t_en = cyc;
            push_pair(1'b1, 24'h00A5A5, 24'h000001, 64'h0000_0000_A5A5_0001);
         end
         begin
            wait_fs(1'b1, 50, t_fs);
            check("b_first_fall_latency", 64'(t_fs - t_en), 64'd8);
         end
      join
      push_pair(1'b1, 24'h001234, 24'h00FEDC, 64'h0000_0000_1234_FEDC);
      check_frame(1'b1, "b_frame");
      wait_fs(1'b1, 300, t_fs);
      push_pair(1'b1, 24'h000F0F, 24'h00F0F0, 64'h0000_0000_0F0F_F0F0);
      repeat (30) @(negedge clk);
      check("b_ready_before_rst", 64'(if_b.s_ready), 64'd0);
      check("b_sck_sd_before_rst", 64'({b_sck, b_sd}), 64'd3);
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      check("b_rst_outputs", 64'({b_sck, b_ws, b_sd, b_fs, b_ur}), 64'd0);
      check("b_rst_ready", 64'(if_b.s_ready), 64'd1);
      sb_b.delete();
      en_b = 1'b0;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S bus master transmitter. Accepts stereo PCM sample pairs over a valid/ready stream and serialises them to an external I2S DAC/amplifier.
- Generates its own bit clock (i2s_clk) and word select (i2s_ws) from the system clock.
- Playback counterpart of the microphone capture path: the same SPI/FIFO infrastructure feeds it samples.
- Uses the Philips I2S format. A one-entry holding register decouples the stream from frame timing.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- I2S_CLK_FREQ, 1_500_000: target bit-clock frequency in Hz.
- DATA_SIZE, 24: sample width in bits, 1..SLOT_WIDTH.
- SLOT_WIDTH, 32: bits per channel slot. A frame is 2*SLOT_WIDTH bit clocks.
- HALF_DIV, derived: CLK_FREQ/(2*I2S_CLK_FREQ), integer-truncated, minimum 1. With defaults this is 16, so one bit = 32 clk and one frame = 2048 clk.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- en, input, 1: transmitter enable.
- s_left, input, DATA_SIZE: left sample, two's complement.
- s_right, input, DATA_SIZE: right sample, two's complement.
- s_valid, input, 1: sample pair valid.
- s_ready, output, 1: holding register can accept a pair.
- i2s_clk, output, 1: bit clock (SCK).
- i2s_ws, output, 1: word select. 0 = left, 1 = right.
- i2s_sd, output, 1: serial data.
- frame_start, output, 1: one-cycle pulse on each frame load edge.
- underrun, output, 1: sticky. Set when a frame is loaded with no pair available.
- clr_underrun, input, 1: clears underrun.

Behaviour:
- Reset values:
  - i2s_clk=0, i2s_ws=0, i2s_sd=0, frame_start=0, underrun=0.
  - Holding register empty, so s_ready=1.
  - Divider count=0, bit index n=2*SLOT_WIDTH-1.
- s_ready = NOT hold_valid. The handshake is s_valid AND s_ready; it captures both samples into the holding register.
  - No same-cycle bypass from the stream into the shift register.
- Divider:
  - While en=1, count goes 0..HALF_DIV-1.
  - At HALF_DIV-1 the count wraps and i2s_clk toggles on the next edge.
  - The first rising SCK edge comes HALF_DIV clk after en rises. The first falling edge comes 2*HALF_DIV clk after en rises.
- Fall event: the cycle in which i2s_clk is registered 1 -> 0. On each fall event:
  - n <= (n+1) mod 2*SLOT_WIDTH.
  - i2s_ws and i2s_sd are registered in the same cycle as i2s_clk, so no skew.
- Load (n becomes 0):
  - Shift register <= {left<<(SLOT_WIDTH-DATA_SIZE), right<<(SLOT_WIDTH-DATA_SIZE)}, i.e. 2*SLOT_WIDTH bits with LSB zero padding.
  - If the hold register is empty: load zeros and set underrun.
  - frame_start pulses for one cycle.
  - Hold is freed, so s_ready rises the next cycle.
  - If the hold register is empty at load and s_valid arrives in the same cycle: counts as underrun. The pair is stored for the next frame.
- i2s_sd at index n = shift-register bit (2*SLOT_WIDTH-1-n). This puts the left MSB at n=0 and the right MSB at n=SLOT_WIDTH.
- i2s_ws at index n:
  - 1 for n in [SLOT_WIDTH-1, 2*SLOT_WIDTH-2], otherwise 0.
  - WS therefore leads each MSB by exactly one SCK (Philips format).
- The receiver samples SD/WS on rising SCK, which is mid-bit.
- en deasserted:
  - Takes effect the next cycle, mid-frame included.
  - i2s_clk, i2s_ws, i2s_sd go to 0. Divider and n return to reset values. Current frame is discarded.
  - Hold register and underrun are retained. s_ready still follows hold_valid.
  - Re-enable restarts at a frame boundary.
- underrun: set at a load with no data. Cleared by clr_underrun. If set and clear occur in the same cycle, set wins.
- rst asserted mid-frame: all state returns to reset values next cycle and any held pair is dropped.

Test Plan:
1. Defaults. Reset, en=1, push L=0x800001, R=0x7FFFFE before the first fall event.
   - First fall at clk 32 after en.
   - SD bits 0..31 = 0x80000100; bits 32..63 = 0x7FFFFE00.
   - WS high for n=31..62. underrun stays 0.
2. Continuous stream of 4 pairs, one pushed each time s_ready rises.
   - Frames back-to-back, period exactly 2048 clk. frame_start spacing 2048.
   - s_ready low between push and load. No underrun.
3. en=1 with no data.
   - Frame of all-zero SD. underrun=1 at the first load.
   - clr_underrun pulse -> 0. Next empty frame -> 1 again.
4. s_valid asserted exactly on the load-edge cycle with hold empty.
   - Current frame is zeros and underrun=1.
   - That pair appears in the following frame.
5. Drop en at n=40.
   - Next cycle SCK/WS/SD=0.
   - Re-enable: first fall 32 clk later at n=0 carries the retained hold pair.
6. DATA_SIZE=16, SLOT_WIDTH=16, HALF_DIV=4. Push L=0xA5A5, R=0x0001.
   - Bit period 8 clk. SD = 0xA5A5 then 0x0001. WS high for n=15..30.
   - Assert rst mid-frame: all outputs 0 next cycle, s_ready=1.
